vga_plot_arbiter: RTL

//   Shares the VGA adapter's single pixel-write port (x, y, colour, plot) between several drawing engines
//   (screen clear, line, circle). Round-robin grant with burst locking. One beat is one pixel.

---
 rtl/vga_plot_pkg.sv | 29 ++
 rtl/vga_plot_arbiter_rr_pick.sv | 50 +++++
 rtl/vga_plot_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_plot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_pkg
// Purpose  : Shared constants and types for the VGA pixel-write arbiter:
//            screen geometry, pixel field widths and FSM state encodings.
// Revision : 1.0  initial release
// ============================================================================
package vga_plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    localparam int IDX_W = 3;

    // Arbiter states; the enum documents the encoding, the localparams are
    // what the FSM register is compared against.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } plot_state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

endpackage : vga_plot_pkg
`default_nettype wire

// File: rtl/vga_plot_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter_rr_pick
// Purpose  : Combinational round-robin priority encoder. Returns the first
//            set bit of i_valid searching upward from i_start, with wrap.
// Ports    : i_valid  - request vector
//            i_start  - index searched first (must be < NUM_REQ)
//            o_idx    - selected index (0 when nothing is set)
//            o_any    - at least one request is set
// Revision : 1.0  initial release
// ============================================================================
module vga_plot_arbiter_rr_pick
    import vga_plot_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_start,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [3:0]       w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap by explicit compare so non power-of-two counts work.
            w_cand = {1'b0, i_start} + 4'(k);
            if (w_cand >= 4'(NUM_REQ)) begin
                w_cand = w_cand - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && (w_cand == 4'(j)) && i_valid[j]) begin
                    w_found = 1'b1;
                    w_idx   = IDX_W'(j);
                end
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule : vga_plot_arbiter_rr_pick
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Purpose  : Shares the VGA adapter's single pixel-write port between several
//            drawing engines. Round-robin grant with burst locking; a burst
//            ends on req_last, after MAX_BURST beats, or after the owner has
//            been silent for IDLE_TIMEOUT cycles. One beat is one pixel.
// Ports    : CLOCK_50, reset (sync, active high)
//            req_valid/req_x/req_y/req_colour/req_last  packed requester side
//            req_ready                                  one-hot to owner in BURST
//            vga_x/vga_y/vga_colour/vga_plot            registered adapter side
//            grant_id, busy                             registered status
//            drop_count                                 saturating off-screen count
// Revision : 1.0  initial release
// ============================================================================
module vga_plot_arbiter
    import vga_plot_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16,
    parameter int X_MAX        = SCREEN_W,
    parameter int Y_MAX        = SCREEN_H
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [X_W*NUM_REQ-1:0] req_x,
    input  logic [Y_W*NUM_REQ-1:0] req_y,
    input  logic [C_W*NUM_REQ-1:0] req_colour,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    output logic [15:0]            drop_count
);

    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);
    localparam logic [7:0] c_IDLE_LIM  = 8'(IDLE_TIMEOUT - 1);
    localparam logic [8:0] c_X_MAX     = 9'(X_MAX);
    localparam logic [7:0] c_Y_MAX     = 8'(Y_MAX);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [7:0]       r_beat_cnt;
    logic [7:0]       r_idle_cnt;
    logic [X_W-1:0]   r_vga_x;
    logic [Y_W-1:0]   r_vga_y;
    logic [C_W-1:0]   r_vga_c;
    logic             r_plot;
    logic [15:0]      r_drop;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_ready;
    logic [X_W-1:0]     w_x;
    logic [Y_W-1:0]     w_y;
    logic [C_W-1:0]     w_c;
    logic               w_last;
    logic               w_accept;
    logic [7:0]         w_beat_next;
    logic               w_in_range;
    logic               w_release;
    logic [IDX_W-1:0]   w_next_ptr;

    vga_plot_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Owner selection: ready is a pure function of state, and the owner's
    // fields are muxed onto the shared datapath.
    always_comb begin
        w_ready  = '0;
        w_x      = '0;
        w_y      = '0;
        w_c      = '0;
        w_last   = 1'b0;
        w_accept = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if ((r_state == ST_BURST) && (r_owner == IDX_W'(j))) begin
                w_ready[j] = 1'b1;
                w_x        = req_x[X_W*j +: X_W];
                w_y        = req_y[Y_W*j +: Y_W];
                w_c        = req_colour[C_W*j +: C_W];
                w_last     = req_last[j];
                w_accept   = req_valid[j];
            end
        end
    end

    assign w_beat_next = r_beat_cnt + 8'd1;
    assign w_in_range  = ({1'b0, w_x} < c_X_MAX) && ({1'b0, w_y} < c_Y_MAX);
    assign w_next_ptr  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // The timeout fires on the cycle the idle counter would reach the limit;
    // a beat arriving on that same cycle is still taken before letting go.
    assign w_release = (r_state == ST_BURST) &&
                       ((w_accept && (w_last || (w_beat_next == c_MAX_BURST))) ||
                        (r_idle_cnt == c_IDLE_LIM));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_vga_c    <= '0;
            r_plot     <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_pick_any) begin
                    r_state    <= ST_BURST;
                    r_owner    <= w_pick_idx;
                    r_beat_cnt <= '0;
                    r_idle_cnt <= '0;
                end
            end else begin
                if (w_accept) begin
                    r_beat_cnt <= w_beat_next;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 8'd1;
                end
                if (w_release) begin
                    r_state  <= ST_IDLE;
                    r_rr_ptr <= w_next_ptr;
                end
            end

            r_plot <= w_accept && w_in_range;
            if (w_accept) begin
                r_vga_x <= w_x;
                r_vga_y <= w_y;
                r_vga_c <= w_c;
            end
            if (w_accept && !w_in_range && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign req_ready  = w_ready;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_c;
    assign vga_plot   = r_plot;
    assign grant_id   = r_owner;
    assign busy       = r_state[0];
    assign drop_count = r_drop;

endmodule : vga_plot_arbiter
`default_nettype wire
